// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: op codes, FSM states and iteration modes shared by alu_mc and its iterator.
// ALU_MC_DIV_EN adds the DIV state.
package alu_mc_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    CMP  = 4'd5,
    SLL  = 4'd6,
    SRL  = 4'd7,
    SRA  = 4'd8,
    PASS = 4'd9,
    MUL  = 4'd10,
    DIVU = 4'd11
  } alu_op_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef ALU_MC_DIV_EN
    S_DIV,
`endif
    S_DONE
  } alu_state_t;
  typedef enum logic {IT_MUL, IT_DIV} iter_mode_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle; slave is the ALU side, master the pipeline side.
interface alu_mc_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, kill, out_valid, out_ready, flag, zero, busy;
  logic [3:0] op;
  logic [WIDTH-1:0] op1, op2, res, rem;
  modport slave (
    input in_valid, op, op1, op2, kill, out_ready,
    output in_ready, out_valid, res, rem, flag, zero, busy
  );
  modport master (
    output in_valid, op, op1, op2, kill, out_ready,
    input in_ready, out_valid, res, rem, flag, zero, busy
  );
endinterface

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one shift-add (MUL) or restoring shift-subtract (DIV, with ALU_MC_DIV_EN) step.
// acc holds {high, low}: product halves for MUL, {remainder, quotient/dividend} for DIV.
module alu_mc_iter import alu_mc_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  iter_mode_t         mode,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {sum, acc[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0] trial;
  logic ge;
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge = trial >= {1'b0, opnd};
  // remainder stays below the divisor, so the difference always fits WIDTH bits
  assign nxt = mode == IT_DIV
    ? (ge ? {trial[WIDTH-1:0] - opnd, acc[WIDTH-2:0], 1'b1} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0})
    : mul_nxt;
`else
  assign nxt = mode == IT_DIV ? acc : mul_nxt;
`endif
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU; single-cycle logic/arith ops, iterative MUL and DIVU.
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise DIVU returns an error result in one cycle.
module alu_mc import alu_mc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  alu_mc_if.slave io
);
  alu_state_t state, state_n, start_st;
  iter_mode_t mode;
  logic [SHW-1:0] cnt, amt;
  logic [SHW:0] sh;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH:0] wide;
  logic [WIDTH-1:0] opnd, res_q, rem_q, fin_res, fin_rem;
  logic in_ready, accept, busy, last, flag_q, zero_q, fin_flag;
  assign in_ready = rst && !io.kill && (state == S_IDLE || (state == S_DONE && io.out_ready));
  assign accept = io.in_valid && in_ready;
  assign last = busy && cnt == '0;
  assign amt = io.op2[SHW-1:0];
  assign sh = amt == '0 ? (SHW+1)'(WIDTH / 2) : {1'b0, amt};
  assign fin_res = nxt[WIDTH-1:0];
`ifdef ALU_MC_DIV_EN
  assign start_st = io.op == MUL ? S_MUL : io.op == DIVU ? S_DIV : S_DONE;
  assign busy = state == S_MUL || state == S_DIV;
  assign mode = state == S_DIV ? IT_DIV : IT_MUL;
  assign fin_rem = state == S_DIV ? nxt[2*WIDTH-1:WIDTH] : '0;
  assign fin_flag = state == S_DIV ? opnd == '0 : |nxt[2*WIDTH-1:WIDTH];
`else
  assign start_st = io.op == MUL ? S_MUL : S_DONE;
  assign busy = state == S_MUL;
  assign mode = IT_MUL;
  assign fin_rem = '0;
  assign fin_flag = |nxt[2*WIDTH-1:WIDTH];
`endif
  // bit WIDTH of wide carries the flag for every single-cycle op
  always_comb begin
    wide = '0;
    case (io.op)
      ADD:  wide = {1'b0, io.op1} + {1'b0, io.op2};
      SUB:  wide = {1'b0, io.op1} - {1'b0, io.op2};
      AND:  wide = {1'b0, io.op1 & io.op2};
      OR:   wide = {1'b0, io.op1 | io.op2};
      XOR:  wide = {1'b0, io.op1 ^ io.op2};
      CMP:  wide = (WIDTH+1)'(io.op1 != io.op2);
      SLL:  wide = {1'b0, io.op1} << sh;
      SRL:  wide = {1'b0, io.op1 >> sh};
      SRA:  wide = {1'b0, WIDTH'($signed(io.op1) >>> sh)};
      PASS: wide = {1'b0, io.op1};
`ifndef ALU_MC_DIV_EN
      DIVU: wide = '1;
`endif
      default: wide = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = start_st;
    else if (last) state_n = S_DONE;
    else if (state == S_DONE && io.out_ready) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst || io.kill) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      res_q <= '0;
      rem_q <= '0;
      flag_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= SHW'(WIDTH - 1);
        acc <= {{WIDTH{1'b0}}, io.op1};
        opnd <= io.op2;
        res_q <= wide[WIDTH-1:0];
        rem_q <= '0;
        flag_q <= wide[WIDTH];
        zero_q <= wide[WIDTH-1:0] == '0;
      end else if (busy) begin
        cnt <= cnt - SHW'(1);
        acc <= nxt;
        if (last) begin
          res_q <= fin_res;
          rem_q <= fin_rem;
          flag_q <= fin_flag;
          zero_q <= fin_res == '0;
        end
      end
    end
  end
  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (.acc(acc), .opnd(opnd), .mode(mode), .nxt(nxt));
  assign io.in_ready = in_ready;
  assign io.out_valid = state == S_DONE;
  assign io.busy = busy;
  assign io.res = res_q;
  assign io.rem = rem_q;
  assign io.flag = flag_q;
  assign io.zero = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;
  localparam int W = 16;
  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic flag;
    int lat;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  exp_t sb[$];
  alu_mc_if #(.WIDTH(W)) io();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int unsigned ua, ub, sh, full;
    int sa;
    ua = a;
    ub = b;
    sh = (b[3:0] == 4'd0) ? 8 : b[3:0];
    sa = int'(ua) - (a[15] ? 65536 : 0);
    e.res = '0;
    e.rem = '0;
    e.flag = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      ADD: begin full = ua + ub; e.res = full[15:0]; e.flag = full > 32'hFFFF; end
      SUB: begin full = ua - ub; e.res = full[15:0]; e.flag = ua < ub; end
      AND: e.res = a & b;
      OR: e.res = a | b;
      XOR: e.res = a ^ b;
      CMP: e.res = (a == b) ? 16'd0 : 16'd1;
      SLL: begin full = ua << sh; e.res = full[15:0]; e.flag = full[16]; end
      SRL: e.res = 16'(ua >> sh);
      SRA: e.res = 16'(sa >>> sh);
      PASS: e.res = a;
      MUL: begin full = ua * ub; e.res = full[15:0]; e.flag = full[31:16] != 0; e.lat = 17; end
`ifdef ALU_MC_DIV_EN
      DIVU: begin
        e.lat = 17;
        if (ub == 0) begin e.res = 16'hFFFF; e.rem = a; e.flag = 1'b1; end
        else begin e.res = 16'(ua / ub); e.rem = 16'(ua % ub); end
      end
`else
      DIVU: begin e.res = 16'hFFFF; e.flag = 1'b1; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  initial forever begin
    bit ev, eb;
    exp_t e;
    @(negedge clk);
    ncyc++;
    if (rst) begin
      ev = sb.size() > 0 && ncyc - sb[0].acc >= sb[0].lat;
      eb = sb.size() > 0 && sb[0].lat > 1 && ncyc - sb[0].acc < sb[0].lat;
      chk("out_valid", io.out_valid, ev);
      chk("busy", io.busy, eb);
      if (ev && io.out_valid) begin
        chk("res", io.res, sb[0].res);
        chk("rem", io.rem, sb[0].rem);
        chk("flag", io.flag, sb[0].flag);
        chk("zero", io.zero, sb[0].res == 16'd0);
        if (io.out_ready && !io.kill) void'(sb.pop_front());
      end
    end
    if (io.kill || !rst) sb.delete();
    else if (io.in_valid && io.in_ready) begin
      e = model(io.op, io.op1, io.op2);
      e.acc = ncyc;
      sb.push_back(e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit rnd);
    int n = 0;
    bit ok;
    io.in_valid = 1'b1;
    io.op = op;
    io.op1 = a;
    io.op2 = b;
    do begin
      if (rnd) begin
        io.out_ready = $urandom_range(0, 3) != 0;
        io.kill = $urandom_range(0, 19) == 0;
      end
      @(negedge clk);
      ok = io.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    io.in_valid = 1'b0;
    io.kill = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input string name, input logic [15:0] r, input logic [15:0] rm,
                             input logic f, input int lat, input int bsy);
    int n = 0;
    int b = 0;
    do begin
      @(negedge clk);
      n++;
      if (io.busy) b++;
    end while (!io.out_valid && n < 40);
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_cycles"}, b, bsy);
    chk({name, "_res"}, io.res, r);
    chk({name, "_rem"}, io.rem, rm);
    chk({name, "_flag"}, io.flag, f);
    chk({name, "_zero"}, io.zero, r == 16'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"}, io.in_ready, 0);
    chk({name, "_out_valid"}, io.out_valid, 0);
    chk({name, "_busy"}, io.busy, 0);
    chk({name, "_res"}, io.res, 0);
    chk({name, "_rem"}, io.rem, 0);
    chk({name, "_flag"}, io.flag, 0);
    chk({name, "_zero"}, io.zero, 0);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    exp_t m;
    int saw;
    io.in_valid = 1'b0;
    io.op = '0;
    io.op1 = '0;
    io.op2 = '0;
    io.kill = 1'b0;
    io.out_ready = 1'b1;
    m = model(ADD, 16'hFFFF, 16'h0001);
    chk("model_add", {m.flag, m.res}, 17'h10000);
    m = model(SRA, 16'h8000, 16'h0000);
    chk("model_sra", m.res, 16'hFF80);
    m = model(MUL, 16'h0100, 16'h0100);
    chk("model_mul", {m.flag, m.res}, 17'h10000);
    m = model(SUB, 16'h0003, 16'h0005);
    chk("model_sub", {m.flag, m.res}, 17'h1FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_release_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    issue(ADD, 16'hFFFF, 16'h0001, 0);
    wait_result("add", 16'h0000, 16'h0000, 1'b1, 1, 0);
    issue(SUB, 16'h0003, 16'h0005, 0);
    wait_result("sub", 16'hFFFE, 16'h0000, 1'b1, 1, 0);
    issue(SRA, 16'h8000, 16'h0000, 0);
    wait_result("sra", 16'hFF80, 16'h0000, 1'b0, 1, 0);
    issue(SLL, 16'h0081, 16'h0001, 0);
    wait_result("sll", 16'h0102, 16'h0000, 1'b0, 1, 0);
    issue(MUL, 16'h0100, 16'h0100, 0);
    wait_result("mul", 16'h0000, 16'h0000, 1'b1, 17, 16);
`ifdef ALU_MC_DIV_EN
    issue(DIVU, 16'd100, 16'd7, 0);
    wait_result("divu", 16'd14, 16'd2, 1'b0, 17, 16);
    issue(DIVU, 16'd5, 16'd0, 0);
    wait_result("divu_zero", 16'hFFFF, 16'd5, 1'b1, 17, 16);
`else
    issue(DIVU, 16'd5, 16'd0, 0);
    wait_result("divu_off", 16'hFFFF, 16'd0, 1'b1, 1, 0);
`endif
    io.out_ready = 1'b0;
    issue(ADD, 16'd1, 16'd2, 0);
    io.in_valid = 1'b1;
    io.op = XOR;
    io.op1 = 16'h00F0;
    io.op2 = 16'h0FF0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", io.in_ready, 0);
      chk("bp_out_valid", io.out_valid, 1);
      chk("bp_res_stable", io.res, 16'd3);
      @(posedge clk);
      #1;
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", io.out_valid, 1);
    chk("bp_next_res", io.res, 16'h0F00);
    @(posedge clk);
    #1;
    issue(MUL, 16'h1234, 16'h0056, 0);
    repeat (7) @(posedge clk);
    #1;
    io.kill = 1'b1;
    @(posedge clk);
    #1;
    io.kill = 1'b0;
    @(negedge clk);
    chk("kill_out_valid", io.out_valid, 0);
    chk("kill_busy", io.busy, 0);
    chk("kill_in_ready", io.in_ready, 1);
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (io.out_valid) saw++;
    end
    chk("kill_no_result", saw, 0);
    @(posedge clk);
    #1;
`ifdef ALU_MC_DIV_EN
    issue(DIVU, 16'hBEEF, 16'h0013, 0);
`else
    issue(MUL, 16'hBEEF, 16'h0013, 0);
`endif
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("midop_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midop_release_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        io.out_ready = $urandom_range(0, 1);
        @(posedge clk);
        #1;
      end
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1);
    end
    io.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_pending", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
